// File: rtl/shift_add_mult16_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width, FSM
// encoding and the state decode used to fold the unused encoding back to IDLE.
`ifndef SIZE
`define SIZE 16
`endif

package shift_add_mult16_pkg;

    localparam int SIZE = `SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding 2'd3 can only appear through an upset; treat it as IDLE.
    function automatic state_t decode_state(input logic [1:0] s);
        state_t d;
        case (s)
            2'd1:    d = RUN;
            2'd2:    d = DONE;
            default: d = IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/shift_add_mult16_if.sv
// Operand/product handshake bundle of the multiplier. The master side supplies
// operands and consumes products; the slave side is the multiplier itself.
interface shift_add_mult16_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );
endinterface

// File: rtl/shift_add_mult16_adder0.sv
// Combinational ripple-carry adder used once per multiplier iteration.
// One full-adder cell per bit, carry chained from LSB to MSB.
module adder0 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential unsigned shift-and-add multiplier: one adder pass per clock for
// WIDTH clocks, product presented over a valid/ready handshake.
module shift_add_mult16
    import shift_add_mult16_pkg::*;
#(
    parameter int WIDTH = SIZE
) (
    input  logic               clk,
    input  logic               rst,
    shift_add_mult16_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_reg, state_next, state_cur;
    logic [WIDTH-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]     acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0]     acc_lo_reg, acc_lo_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;

    assign state_cur = decode_state(state_reg);

    // The multiplier bit under test is always the LSB of the low accumulator.
    assign addend = acc_lo_reg[0] ? mcand_reg : '0;

    adder0 #(
        .WIDTH (WIDTH)
    ) u_adder0 (
        .a    (acc_hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            acc_hi_reg  <= acc_hi_next;
            acc_lo_reg  <= acc_lo_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_cur;
        mcand_next   = mcand_reg;
        acc_hi_next  = acc_hi_reg;
        acc_lo_next  = acc_lo_reg;
        count_next   = count_reg;
        product_next = product_reg;

        case (state_cur)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next  = RUN;
                    mcand_next  = bus.a;
                    acc_lo_next = bus.b;
                    acc_hi_next = '0;
                    count_next  = '0;
                end
            end
            RUN: begin
                // {cout, sum, acc_lo} shifted right by one; the carry lands in the MSB.
                acc_hi_next = {cout, sum[WIDTH-1:1]};
                acc_lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};
                count_next  = count_reg + 1'b1;
                if (count_reg == LAST) begin
                    state_next   = DONE;
                    product_next = {acc_hi_next, acc_lo_next};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_cur == IDLE);
    assign bus.out_valid = (state_cur == DONE);
    assign bus.busy      = (state_cur == RUN) || (state_cur == DONE);
    assign bus.product   = product_reg;

endmodule

// File: tb/tb_shift_add_mult16.sv
// Self-checking bench for shift_add_mult16: directed cases plus randomized
// operands and backpressure, checked against plain a*b arithmetic.
module tb_shift_add_mult16;

    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] last_product;

    shift_add_mult16_if #(.WIDTH(WIDTH)) bus ();

    shift_add_mult16 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. bp = cycles of held-off out_ready after DONE;
    // poke drives in_valid during the DONE handshake cycle.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input int bp, input bit poke);
        logic [31:0] exp;
        int          n;
        exp = 32'(av) * 32'(bv);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", 64'(bus.in_ready), 64'd1);
        bus.out_ready = (bp == 0);
        bus.a         = av;
        bus.b         = bv;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
        check("run_in_ready", 64'(bus.in_ready), 64'd0);
        check("run_busy", 64'(bus.busy), 64'd1);
        for (int i = 1; i < WIDTH; i++) begin
            step();
            if (i == WIDTH / 2) check("run_product_hold", 64'(bus.product), 64'(last_product));
        end
        check("no_early_valid", 64'(bus.out_valid), 64'd0);
        step();
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("product", 64'(bus.product), 64'(exp));
        last_product = exp;
        for (int i = 0; i < bp; i++) begin
            bus.in_valid = 1'(i % 2);
            step();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_product", 64'(bus.product), 64'(exp));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = poke;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        check("post_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_busy", 64'(bus.busy), 64'd0);
        check("post_product", 64'(bus.product), 64'(exp));
        $display("txn a=%04h b=%04h bp=%0d product=%08h exp=%08h", av, bv, bp, bus.product, exp);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        last_product  = 32'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1111;
        bus.b         = 16'h2222;
        bus.out_ready = 1'b1;

        // in_valid asserted throughout reset must be ignored
        repeat (3) step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        step();
        check("idle_busy", 64'(bus.busy), 64'd0);

        do_op(16'h0001, 16'h0001, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 0, 1'b1);
        do_op(16'hAAAA, 16'h5555, 0, 1'b0);
        do_op(16'h1234, 16'h0000, 0, 1'b0);
        do_op(16'hBEEF, 16'h0101, 5, 1'b0);

        // Asynchronous reset between edges 8 and 9 of a long run
        bus.out_ready = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'hFFFF;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        repeat (8) step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_product", 64'(bus.product), 64'd0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        #2;
        rst = 1'b0;
        last_product = 32'd0;
        step();
        check("after_rst_busy", 64'(bus.busy), 64'd0);
        do_op(16'h0003, 16'h0005, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
